even_parity_serial_tx: RTL and testbench
========================================

# even_parity_serial_tx

- Serial even-parity frame transmitter.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- Appends one even-parity bit so each transmitted frame {parity, data} has an even number of ones.
- Drives the transmit end of the serial parity link. The even parity checker on the receive side consumes the reassembled {pb, data} word.

## Interface
Parameters:
- DATA_W, default 3: data bits per frame; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is presented this cycle.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA_W  word to transmit; sampled only on handshake.
- ser_out  output  1  serial bit: data bits LSB-first, then the parity bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_first  output  1  high with data bit 0 of a frame.
- ser_last  output  1  high with the parity bit of a frame.
- busy  output  1  a frame is in flight.

## Operation
- Handshake: a word is accepted on a rising edge where in_valid and in_ready are both 1. in_valid may rise independently of in_ready. in_data must be held until accepted.
- Parity: computed as the XOR reduction of in_data at acceptance and registered with the word.
  - Result: parity is 1 exactly when in_data has an odd count of ones.
- State machine: IDLE, DATA, PARITY.
  - IDLE: in_ready=1, ser_valid=0. On handshake, load the shift register and parity, clear bit_cnt, go to DATA.
  - DATA: ser_out=shreg[0], ser_valid=1, ser_first=(bit_cnt==0).
    - Each cycle the register shifts right and bit_cnt increments.
    - When bit_cnt==DATA_W-1, go to PARITY.
  - PARITY: ser_out=parity, ser_valid=1, ser_last=1, in_ready=1.
    - On handshake, reload and go to DATA; the next frame follows with zero gap.
    - Otherwise go to IDLE.
- bit_cnt width is clog2(DATA_W) with a minimum of 1. It never wraps past DATA_W-1.
- DATA_W=1: DATA lasts one cycle. That cycle has ser_first=1.
- in_ready is 0 throughout DATA. in_valid is ignored there.
- busy=1 in DATA and PARITY.

## Timing
- Reset values: in_ready=0 while rst_n=0, then 1 from the first edge after release (IDLE).
  - ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - All outputs are registered or decoded from registered state only; there is no combinational in_data→ser_out path.
- Latency: handshake at edge k puts data bit 0 on ser_out during cycle k+1.
  - Bit i appears in cycle k+1+i.
  - The parity bit appears in cycle k+1+DATA_W.
- Frame length: DATA_W+1 cycles.
- Throughput with in_valid held high: one frame per DATA_W+1 cycles, no idle cycles.
- Reset mid-frame: the frame is abandoned and all outputs drop to reset values asynchronously.
  - No partial parity bit is ever emitted.
  - After release, the block waits in IDLE for a new handshake.
- Handshake in the PARITY cycle and the parity bit output happen in the same cycle. The new frame's bit 0 follows in the next cycle.
- A word accepted in the same cycle that rst_n deasserts is not accepted: in_ready is still 0 on that edge.

## Structure
- Shared package parity_pkg holds:
  - the state enum {IDLE, DATA, PARITY};
  - DATA_W_DEFAULT=3;
  - a function even_parity(data) returning the XOR reduction. The checker uses the same function.
- The shift register, counter and FSM stay in one flat module. There is no sub-module.

## Test plan
- Data 3'b011 accepted at edge k: ser_out is 1,1,0 in cycles k+1..k+3 and parity 0 in k+4.
  - ser_first high only in k+1; ser_last high only in k+4.
- Data 3'b111: serial 1,1,1 then parity 1. Data 3'b000: serial 0,0,0 then parity 0. busy stays high for exactly 4 cycles.
- Back-to-back: in_valid held high with 3'b101 then 3'b100.
  - Required stream: 1,0,1,0, then 0,0,1,1.
  - ser_valid is continuous for 8 cycles; in_ready is high only in the two PARITY cycles after the first accept.
- Reset mid-frame: assert rst_n=0 during bit 1 of 3'b110.
  - All outputs are 0 immediately, with no ser_last pulse.
  - After release, in_ready=1 and the next frame, 3'b001, transmits as 1,0,0,1.
- Exhaustive loopback: all 8 values 3'b000..3'b111, deserialized into {pb, data}.
  - Every frame has even weight, i.e. the checker reports no error. The deserialized data equals the input.
- Stall: in_valid low for 5 cycles while in IDLE. ser_valid stays 0 and the block stays in IDLE with no spurious output.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial even-parity link.
// Used by both the transmitter and the receive-side checker.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  localparam int unsigned DATA_W_DEFAULT = 3;

  // Zero-extension of narrower words leaves the XOR reduction unchanged.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx.sv
// Serial even-parity frame transmitter: accepts a word on valid/ready and
// shifts it out LSB-first, followed by one even-parity bit.
module even_parity_serial_tx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              parity_q, parity_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Holds in_ready low on the release edge so no word is taken out of reset.
  logic              init_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      init_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready = init_q;
        if (in_valid && init_q) begin
          shreg_d  = in_data;
          parity_d = even_parity(32'(in_data));
          cnt_d    = '0;
          state_d  = StData;
        end
      end
      StData: begin
        ser_out   = shreg_q[0];
        ser_valid = 1'b1;
        ser_first = (cnt_q == '0);
        busy      = 1'b1;
        shreg_d   = shreg_q >> 1;
        if (cnt_q == LastCnt) begin
          state_d = StParity;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        ser_out   = parity_q;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        busy      = 1'b1;
        in_ready  = 1'b1;
        // Reloading here lets the next frame follow with no gap.
        if (in_valid) begin
          shreg_d  = in_data;
          parity_d = even_parity(32'(in_data));
          cnt_d    = '0;
          state_d  = StData;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench: directed and random traffic against a queue-based
// frame model, plus a loopback receiver that checks frame weight and data.
module tb_even_parity_serial_tx;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         ser_out, ser_valid, ser_first, ser_last, busy;

  even_parity_serial_tx #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } sbit_t;

  sbit_t        exp_q[$];
  logic [W-1:0] words[$];
  bit           init_m = 1'b0;
  logic [W:0]   rx_frame = '0;
  int           rx_cnt = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check this cycle's outputs, drive inputs, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic hs);
    sbit_t e;
    logic  exp_ready;
    @(negedge clk);
    exp_ready = (exp_q.size() == 0) ? init_m : (exp_q.size() == 1);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("ser_valid", 32'(ser_valid), 32'd1);
      check("ser_out", 32'(ser_out), 32'(e.b));
      check("ser_first", 32'(ser_first), 32'(e.f));
      check("ser_last", 32'(ser_last), 32'(e.l));
      check("busy", 32'(busy), 32'd1);
    end else begin
      check("idle_valid", 32'(ser_valid), 32'd0);
      check("idle_out", 32'(ser_out), 32'd0);
      check("idle_first", 32'(ser_first), 32'd0);
      check("idle_last", 32'(ser_last), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    // Loopback receiver reassembles {pb, data}.
    if (ser_valid) begin
      if (rx_cnt <= int'(W)) rx_frame[rx_cnt] = ser_out;
      rx_cnt++;
      if (ser_last) begin
        check("lb_len", 32'(rx_cnt), 32'(W + 1));
        check("lb_weight", 32'($countones(rx_frame) % 2), 32'd0);
        if (words.size() > 0) check("lb_data", 32'(rx_frame[W-1:0]), 32'(words.pop_front()));
        else check("lb_spurious", 32'd1, 32'd0);
        rx_cnt = 0;
      end
    end
    in_valid = v;
    in_data  = d;
    rst_n    = r;
    @(posedge clk);
    hs = v && exp_ready && r;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (hs) begin
      for (int i = 0; i < int'(W); i++) exp_q.push_back('{b: d[i], f: (i == 0), l: 1'b0});
      exp_q.push_back('{b: ($countones(d) % 2 == 1), f: 1'b0, l: 1'b1});
      words.push_back(d);
    end
    if (r) init_m = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] d);
    logic hs;
    hs = 1'b0;
    for (int t = 0; t < 20 && !hs; t++) step(1'b1, d, 1'b1, hs);
    if (!hs) check("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), rst_n, hs);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", 32'(ser_out), 32'd0);
    check("rst_valid", 32'(ser_valid), 32'd0);
    check("rst_first", 32'(ser_first), 32'd0);
    check("rst_last", 32'(ser_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    words.delete();
    rx_cnt = 0;
    init_m = 1'b0;
  endtask

  initial begin
    logic         hs;
    logic         pend;
    logic [W-1:0] pd;

    // Reset, with in_valid high on the release edge: that word must not be taken.
    step(1'b0, '0, 1'b0, hs);
    step(1'b0, '0, 1'b0, hs);
    step(1'b1, 3'b010, 1'b1, hs);
    check("no_accept_on_release", 32'(hs), 32'd0);
    step(1'b0, '0, 1'b1, hs);
    idle(1);

    send(3'b011);
    idle(6);
    send(3'b111);
    idle(6);
    send(3'b000);
    idle(6);

    // Back-to-back with in_valid held high.
    send(3'b101);
    send(3'b100);
    idle(6);

    // Reset during bit 1 of a frame.
    send(3'b110);
    step(1'b0, '0, 1'b1, hs);
    async_reset();
    step(1'b0, '0, 1'b0, hs);
    step(1'b0, '0, 1'b1, hs);
    send(3'b001);
    idle(6);

    for (int v = 0; v < 8; v++) send(W'(v));
    idle(6);

    // Stall in IDLE.
    idle(5);

    // Random traffic with occasional mid-cycle resets.
    pend = 1'b0;
    pd   = '0;
    for (int c = 0; c < 600; c++) begin
      if (rst_n && $urandom_range(0, 79) == 0) begin
        async_reset();
        pend = 1'b0;
        step(1'b0, '0, 1'b0, hs);
        step(1'b0, '0, 1'b1, hs);
      end else begin
        if (!pend) begin
          pd   = W'($urandom);
          pend = ($urandom_range(0, 2) != 0);
        end
        step(pend, pd, 1'b1, hs);
        if (hs) pend = 1'b0;
      end
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
